// File: rtl/note_voice_alloc_if.sv
// Event and voice bus between the note decoder, the voice allocator and the tone generators.
// master drives note events; slave (the allocator) drives the per-voice outputs.
interface note_voice_alloc_if #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 5,
    parameter int CNT_W      = $clog2(NUM_VOICES + 1)
);
    logic                         ev_valid;
    logic                         ev_release;
    logic [NOTE_W-1:0]            ev_note;
    logic                         all_off;
    logic [NUM_VOICES-1:0]        voice_on;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic [NUM_VOICES-1:0]        voice_start;
    logic                         steal_tick;
    logic [CNT_W-1:0]             active_count;

    modport master (
        output ev_valid, ev_release, ev_note, all_off,
        input  voice_on, voice_note, voice_start, steal_tick, active_count
    );

    modport slave (
        input  ev_valid, ev_release, ev_note, all_off,
        output voice_on, voice_note, voice_start, steal_tick, active_count
    );
endinterface

// File: rtl/note_voice_alloc.sv
// Polyphony scheduler: maps press/release note events onto NUM_VOICES tone generators,
// stealing the oldest voice when all are busy. Single-cycle datapath, registered outputs.
module note_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 5,
    parameter int AGE_W      = 3
) (
    input  logic                clk,
    input  logic                reset,
    note_voice_alloc_if.slave   bus
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [NOTE_W-1:0] NOTE_MAX = NOTE_W'(21);

    logic [NUM_VOICES-1:0] on_q, on_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] start_q, start_d;
    logic                  steal_q, steal_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  ev_ok;
    logic                  hit, free_any;
    logic [IDX_W-1:0]      hit_idx, free_idx, old_idx, target;
    logic [AGE_W-1:0]      old_age;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
    endfunction

    // Note-match comparators, lowest free voice, and oldest voice (ties keep lowest index).
    always_comb begin
        ev_ok    = bus.ev_valid && !bus.all_off &&
                   (bus.ev_note != '0) && (bus.ev_note <= NOTE_MAX);
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        old_age  = age_q[0];
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (on_q[v] && note_q[v] == bus.ev_note) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(v);
            end
            if (!on_q[v]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(v);
            end
        end
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > old_age) begin
                old_age = age_q[v];
                old_idx = IDX_W'(v);
            end
        end
    end

    always_comb begin
        on_d    = on_q;
        note_d  = note_q;
        age_d   = age_q;
        start_d = '0;
        steal_d = 1'b0;
        target  = free_any ? free_idx : old_idx;
        cnt_d   = '0;
        if (bus.all_off) begin
            on_d = '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_d[v] = '0;
                age_d[v]  = '0;
            end
        end else if (ev_ok && !bus.ev_release) begin
            if (hit) begin
                start_d[hit_idx] = 1'b1;
            end else begin
                steal_d = !free_any;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (IDX_W'(v) == target) begin
                        on_d[v]    = 1'b1;
                        note_d[v]  = bus.ev_note;
                        age_d[v]   = '0;
                        start_d[v] = 1'b1;
                    end else if (on_q[v]) begin
                        age_d[v] = age_inc(age_q[v]);
                    end
                end
            end
        end else if (ev_ok && hit) begin
            on_d[hit_idx]   = 1'b0;
            note_d[hit_idx] = '0;
            age_d[hit_idx]  = '0;
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            cnt_d = cnt_d + CNT_W'(on_d[v]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_q    <= '0;
            start_q <= '0;
            steal_q <= 1'b0;
            cnt_q   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                age_q[v]  <= '0;
            end
        end else begin
            on_q    <= on_d;
            start_q <= start_d;
            steal_q <= steal_d;
            cnt_q   <= cnt_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= note_d[v];
                age_q[v]  <= age_d[v];
            end
        end
    end

    always_comb begin
        bus.voice_note = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            bus.voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
        end
    end

    assign bus.voice_on     = on_q;
    assign bus.voice_start  = start_q;
    assign bus.steal_tick   = steal_q;
    assign bus.active_count = cnt_q;
endmodule

// File: tb/tb_note_voice_alloc.sv
// Scoreboard bench for note_voice_alloc: directed scenarios plus random events,
// expectations from a slot-list reference model of the allocation rules.
module tb_note_voice_alloc;
    localparam int NV = 4;
    localparam int NW = 5;
    localparam int AW = 3;
    localparam int AGE_MAX = (1 << AW) - 1;

    typedef struct packed {
        logic [NV-1:0]    on;
        logic [NV*NW-1:0] notes;
        logic [NV-1:0]    start;
        logic             steal;
        logic [2:0]       cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_voice_alloc_if #(.NUM_VOICES(NV), .NOTE_W(NW)) bus ();

    note_voice_alloc #(.NUM_VOICES(NV), .NOTE_W(NW), .AGE_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    // Model: each slot holds a note (0 = free) and an integer age.
    int m_note [NV];
    int m_age  [NV];

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0;
            m_age[i]  = 0;
        end
    endtask

    task automatic model(input bit v, input bit rel, input int n, input bit off, output exp_t e);
        int hit, tgt, c;
        e = '0;
        if (off) begin
            model_clear();
        end else if (v && n >= 1 && n <= 21) begin
            hit = -1;
            for (int i = 0; i < NV; i++) if (m_note[i] == n) hit = i;
            if (!rel) begin
                if (hit >= 0) begin
                    e.start[hit] = 1'b1;
                end else begin
                    tgt = -1;
                    for (int i = 0; i < NV; i++) if (m_note[i] == 0 && tgt < 0) tgt = i;
                    if (tgt < 0) begin
                        e.steal = 1'b1;
                        tgt = 0;
                        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
                    end
                    for (int i = 0; i < NV; i++)
                        if (i != tgt && m_note[i] != 0)
                            m_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
                    m_note[tgt]  = n;
                    m_age[tgt]   = 0;
                    e.start[tgt] = 1'b1;
                end
            end else if (hit >= 0) begin
                m_note[hit] = 0;
                m_age[hit]  = 0;
            end
        end
        c = 0;
        for (int i = 0; i < NV; i++) begin
            e.on[i] = (m_note[i] != 0);
            e.notes[i*NW +: NW] = NW'(m_note[i]);
            if (m_note[i] != 0) c++;
        end
        e.cnt = 3'(c);
    endtask

    task automatic step(input bit v, input bit rel, input int n, input bit off);
        exp_t e;
        @(negedge clk);
        bus.ev_valid   = v;
        bus.ev_release = rel;
        bus.ev_note    = n[NW-1:0];
        bus.all_off    = off;
        model(v, rel, n[NW-1:0], off, e);
        q.push_back(e);
    endtask

    task automatic press(input int n);   step(1'b1, 1'b0, n, 1'b0); endtask
    task automatic release_(input int n); step(1'b1, 1'b1, n, 1'b0); endtask
    task automatic idle();               step(1'b0, 1'b0, 0, 1'b0); endtask
    task automatic panic();              step(1'b0, 1'b0, 0, 1'b1); endtask

    // Monitor: outputs are presented every cycle; pop one expectation per edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a.on = bus.voice_on;
                a.notes = bus.voice_note;
                a.start = bus.voice_start;
                a.steal = bus.steal_tick;
                a.cnt = bus.active_count;
                total++;
                if (a == e) passed++;
                else $display("FAIL outputs cyc%0d got on=%b notes=%h start=%b steal=%b cnt=%0d want on=%b notes=%h start=%b steal=%b cnt=%0d",
                              cyc, a.on, a.notes, a.start, a.steal, a.cnt,
                              e.on, e.notes, e.start, e.steal, e.cnt);
            end
        end
    end

    task automatic check_reset_state(input string name);
        total++;
        if (bus.voice_on == '0 && bus.voice_note == '0 && bus.voice_start == '0 &&
            bus.steal_tick == 1'b0 && bus.active_count == '0)
            passed++;
        else
            $display("FAIL %s got on=%b notes=%h start=%b steal=%b cnt=%0d want all zero",
                     name, bus.voice_on, bus.voice_note, bus.voice_start,
                     bus.steal_tick, bus.active_count);
    endtask

    initial begin
        int v, rel, n, off;
        reset          = 1'b1;
        bus.ev_valid   = 1'b0;
        bus.ev_release = 1'b0;
        bus.ev_note    = '0;
        bus.all_off    = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_state("reset_state");
        reset = 1'b0;

        // Single press, pulse lasts one cycle
        press(8); idle(); idle();
        // Fill four voices then steal the oldest
        panic(); press(8); press(10); press(12); press(14); press(15); idle();
        // Release frees lowest voice for reuse
        panic(); press(8); press(10); release_(8); press(12); idle();
        // Retrigger held note; release of unheld note ignored
        panic(); press(8); idle(); press(8); release_(3); idle();
        // all_off beats a simultaneous press
        panic(); press(1); press(2); press(3); press(4);
        step(1'b1, 1'b0, 20, 1'b1); idle();
        // Out-of-range notes ignored
        press(0); press(25); release_(0); release_(31); idle();
        // Age saturation then tie-break on steal
        press(1); press(2);
        for (int i = 0; i < 9; i++) begin press(3); release_(3); end
        press(4); press(5); press(6); idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 9) < 8);
            rel = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 9))
                0:       n = $urandom_range(22, 31);
                1:       n = 0;
                2:       n = $urandom_range(1, 21);
                default: n = $urandom_range(1, 8);
            endcase
            off = ($urandom_range(0, 59) == 0);
            step(v[0], rel[0], n, off[0]);
        end

        // Asynchronous reset mid-cycle with three voices active
        panic(); press(5); press(6); press(7); idle();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        model_clear();
        reset = 1'b0;
        press(9); idle();

        repeat (4) @(posedge clk);
        #2;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain got %0d pending want 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/note_voice_alloc.md
Name: note_voice_alloc

Overview:
- Polyphony scheduler between the keyboard note decoder and a bank of NUM_VOICES tone generators.
- Consumes press/release note events and assigns each pressed note to a free voice; the oldest voice is stolen when all are busy. A voice is freed when its note is released.
- Drives per-voice note index, on flag and start pulse to the tone/envelope generators.

Parameters:
NUM_VOICES, 4, number of tone-generator voices shared among keys (2..8)
NOTE_W, 5, width of note index; valid notes 1..21, 0 = no note
AGE_W, 3, width of per-voice age counter; must satisfy 2^AGE_W >= NUM_VOICES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ev_valid  input  1  one-cycle event strobe from note decoder
ev_release  input  1  qualifies ev_valid: 0 = key press, 1 = key release
ev_note  input  NOTE_W  note index of event (1..21)
all_off  input  1  synchronous panic: free every voice
voice_on  output  NUM_VOICES  bit v = voice v currently holds a note
voice_note  output  NUM_VOICES*NOTE_W  note of voice v at bits [v*NOTE_W +: NOTE_W]; 0 when voice is off
voice_start  output  NUM_VOICES  one-cycle pulse: voice v (re)assigned this cycle, for envelope retrigger
steal_tick  output  1  one-cycle pulse: an allocation evicted an active voice
active_count  output  clog2(NUM_VOICES+1)  number of set voice_on bits

Behaviour:
- Reset (async): voice_on=0, voice_note all 0, voice_start=0, steal_tick=0, ages 0, active_count=0.
- All outputs are registered. An event sampled at edge N is reflected in the outputs after edge N. voice_start and steal_tick are high for exactly the cycle following that edge.
- No backpressure: one event per cycle is accepted and fully processed in one cycle.
- ev_valid with ev_note==0 or ev_note>21: ignored, no state change.
- Press, note already held by voice v: no reallocation. voice_start[v] pulses (retrigger); ages are unchanged.
- Press, note not held, at least one free voice: take the lowest-index free voice v.
  - voice_note[v]=ev_note, voice_on[v]=1, age[v]=0, voice_start[v]=1.
  - Every other active voice: age+1, saturating at 2^AGE_W-1.
- Press, all voices busy: steal the voice with the largest age (tie -> lowest index).
  - Same updates as a free allocation, plus steal_tick=1.
- Release, note held by voice v: voice_on[v]=0, voice_note[v]=0, age[v]=0. No pulses.
- Release of a note held by no voice (already stolen, or never pressed): ignored.
- A note is held by at most one voice at any time. This invariant must never be violated.
- all_off=1: all voices freed, ages cleared, no pulses. all_off has priority over a simultaneous ev_valid; that event is dropped.
- active_count is updated in the same cycle as voice_on and always equals popcount(voice_on).
- Reset asserted mid-operation: outputs return to reset values immediately; any pending pulse is lost.
- Implementation is a single-cycle datapath: free-voice priority encoder, note-match comparators, max-age search, and age registers per voice.

Test Plan:
- Reset then press note 8 -> next cycle voice_on=0001, voice_note[0]=8, voice_start=0001, active_count=1; pulse lasts exactly 1 cycle.
- Press 8,10,12,14 on consecutive cycles, then press 15 (NUM_VOICES=4) -> voice 0 (note 8, oldest) stolen: voice_note[0]=15, steal_tick=1, voice_start=0001, voices 1..3 keep notes 10,12,14.
- Press 8,10; release 8; press 12 -> 12 lands in voice 0 (lowest free), voice_on=0011, no steal_tick.
- Press 8, press 8 again -> voice_on=0001 unchanged, voice_start[0] pulses twice, active_count stays 1; release 3 (unheld) -> no change.
- Four voices active, assert all_off together with press of note 20 -> voice_on=0000, active_count=0, voice_start=0, note 20 not allocated.
- Press note 0 and note 25 -> no change. Assert reset asynchronously mid-cycle while 3 voices active -> outputs clear before next clk edge.
